// File: rtl/instr_fetch_pkg.sv
// Shared types for the fetch stage and its downstream processor.
// Instruction word layout is {opcode[11:8], operand[7:4], imm[3:0]}.
package proc_pkg;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [3:0] imm;
  } instr_t;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_NOP  = 4'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // Word driven to proc while nothing valid has been fetched.
  localparam instr_t INSTR_NOP = '{opcode: OP_NOP, operand: 4'h0, imm: 4'h0};

endpackage

// File: rtl/instr_fetch_if.sv
// Control / program / instruction bus of the fetch stage.
// The master side (controller) programs memory and steers fetch; the
// slave side (instr_fetch) presents instructions.
// Optional macro FETCH_BOUNDS_EN adds the fault signal.
interface instr_fetch_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [11:0]   prog_data;
  logic          run;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [11:0]   instruction;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          halted;
`ifdef FETCH_BOUNDS_EN
  logic          fault;

  modport master (
    output prog_we, prog_addr, prog_data, run, stall, redirect, redirect_pc,
    input  instruction, instr_pc, instr_valid, halted, fault
  );
  modport slave (
    input  prog_we, prog_addr, prog_data, run, stall, redirect, redirect_pc,
    output instruction, instr_pc, instr_valid, halted, fault
  );
`else
  modport master (
    output prog_we, prog_addr, prog_data, run, stall, redirect, redirect_pc,
    input  instruction, instr_pc, instr_valid, halted
  );
  modport slave (
    input  prog_we, prog_addr, prog_data, run, stall, redirect, redirect_pc,
    output instruction, instr_pc, instr_valid, halted
  );
`endif
endinterface

// File: rtl/instr_fetch_mem.sv
// Program memory: DEPTH x 12 bits, one synchronous write port and one
// combinational read port. Contents are deliberately not reset so a
// program survives a reset of the fetch stage.
module instr_mem
  import proc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  instr_t        wdata,
  input  logic [AW-1:0] raddr,
  output instr_t        rdata
);

  instr_t mem_r [DEPTH];

  // Synchronous write; a same-cycle read still sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, IDLE/FETCH/HALT control and
// one-cycle-latency presentation of program memory words to proc.
// Optional macro FETCH_BOUNDS_EN: running off the end of memory halts with
// a fault flag instead of wrapping the PC.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter logic [3:0] HALT_OP = OP_HALT
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
`ifdef FETCH_BOUNDS_EN
  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);
`endif

  fetch_state_t  state_r, state_s;
  logic [AW-1:0] pc_r, pc_s;
  instr_t        instr_r, instr_s;
  logic [AW-1:0] ipc_r, ipc_s;
  logic          valid_r, valid_s;
  logic          halted_r, halted_s;
  // The presented word ends the run; the next free cycle enters HALT.
  logic          pend_r, pend_s;
  instr_t        rdata_s;
  logic          mem_we_s;
`ifdef FETCH_BOUNDS_EN
  logic          fault_r, fault_s;
`endif

  // Memory is only writable while no program is being fetched.
  assign mem_we_s = bus.prog_we && (state_r != FETCH);

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (pc_r),
    .rdata (rdata_s)
  );

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      pc_r     <= '0;
      instr_r  <= INSTR_NOP;
      ipc_r    <= '0;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
      pend_r   <= 1'b0;
`ifdef FETCH_BOUNDS_EN
      fault_r  <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      instr_r  <= instr_s;
      ipc_r    <= ipc_s;
      valid_r  <= valid_s;
      halted_r <= halted_s;
      pend_r   <= pend_s;
`ifdef FETCH_BOUNDS_EN
      fault_r  <= fault_s;
`endif
    end
  end

  // Next-state logic: redirect beats stall, stall beats halt and fetch.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    instr_s  = instr_r;
    ipc_s    = ipc_r;
    valid_s  = valid_r;
    halted_s = halted_r;
    pend_s   = pend_r;
`ifdef FETCH_BOUNDS_EN
    fault_s  = fault_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.run) begin
          state_s = FETCH;
          pc_s    = '0;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (bus.redirect) begin
          valid_s = 1'b0;
          pc_s    = bus.redirect_pc;
          pend_s  = 1'b0;
        end else if (bus.stall) begin
          pend_s  = pend_r;
        end else if (pend_r) begin
          state_s  = HALT;
          valid_s  = 1'b0;
          halted_s = 1'b1;
          pend_s   = 1'b0;
`ifdef FETCH_BOUNDS_EN
          // A pending stop that was not a halt word came from the bound.
          fault_s  = (instr_r.opcode != HALT_OP);
`endif
        end else begin
          instr_s = rdata_s;
          ipc_s   = pc_r;
          valid_s = 1'b1;
          if (rdata_s.opcode == HALT_OP) begin
            pend_s = 1'b1;
          end
`ifdef FETCH_BOUNDS_EN
          else if (pc_r == PC_LAST) begin
            pend_s = 1'b1;
          end
`endif
          else begin
            pc_s = pc_r + AW'(1'b1);
          end
        end
      end
      HALT: begin
        if (bus.run) begin
          state_s  = FETCH;
          pc_s     = '0;
          halted_s = 1'b0;
`ifdef FETCH_BOUNDS_EN
          fault_s  = 1'b0;
`endif
        end else begin
          state_s  = HALT;
        end
      end
      default: begin
        state_s  = IDLE;
        pc_s     = '0;
        instr_s  = INSTR_NOP;
        ipc_s    = '0;
        valid_s  = 1'b0;
        halted_s = 1'b0;
        pend_s   = 1'b0;
`ifdef FETCH_BOUNDS_EN
        fault_s  = 1'b0;
`endif
      end
    endcase
  end

  assign bus.instruction = instr_r;
  assign bus.instr_pc    = ipc_r;
  assign bus.instr_valid = valid_r;
  assign bus.halted      = halted_r;
`ifdef FETCH_BOUNDS_EN
  assign bus.fault       = fault_r;
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage directly upstream of proc. Holds a small writable program memory of 12-bit instructions ({opcode[11:8], operand[7:4], imm[3:0]}) and a program counter. Drives proc's 12-bit instruction input one word per cycle, with stall, branch redirect and halt handling.

Parameters:
DEPTH, 16, program memory depth in words (power of two, 2..256)
AW, $clog2(DEPTH), PC / address width (derived, not overridden)
HALT_OP, 4'hF, opcode that stops fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
prog_we  in  1  program memory write strobe
prog_addr  in  AW  program memory write address
prog_data  in  12  program memory write data
run  in  1  start fetching from PC 0 (level-sampled each cycle)
stall  in  1  downstream not ready; hold current output
redirect  in  1  branch taken; flush and load redirect_pc
redirect_pc  in  AW  branch target
instruction  out  12  instruction word to proc
instr_pc  out  AW  address of the presented instruction
instr_valid  out  1  instruction is valid
halted  out  1  HALT state indicator

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=0, instruction=12'h000, instr_pc=0, instr_valid=0, halted=0. Memory contents are not cleared.
- States: IDLE, FETCH, HALT.
- IDLE: outputs held at reset values. run=1 -> FETCH, pc=0.
- FETCH, per cycle, in priority order:
  - redirect=1: instr_valid<=0, pc<=redirect_pc. This applies even when stall=1. The next cycle fetches the target.
  - stall=1: instruction, instr_pc, instr_valid and pc all held.
  - otherwise: instruction<=mem[pc], instr_pc<=pc, instr_valid<=1, pc<=pc+1. Latency is 1 cycle from PC to output.
- Halt:
  - When the fetched word has opcode==HALT_OP, it is presented with instr_valid=1 and pc stops incrementing.
  - On the next cycle that is neither stalled nor redirected: state->HALT, instr_valid<=0, halted<=1.
  - redirect in that same cycle wins. The halt is cancelled and the state stays FETCH.
- HALT: outputs hold their last instruction and instr_pc. instr_valid=0, halted=1. run=1 -> FETCH with pc=0 and halted<=0.
- PC arithmetic is AW-bit. Increment from DEPTH-1 wraps to 0, unless FETCH_BOUNDS_EN is defined.
- Programming: prog_we is honoured only in IDLE or HALT. In FETCH it is ignored and no write occurs. Writes are synchronous, and a read in the same cycle returns old data.
- run while in FETCH is ignored.
- Reset mid-fetch: returns immediately to IDLE with reset outputs, and pending redirect/halt are discarded.

Optional Feature:
FETCH_BOUNDS_EN.
- Defined: an increment from pc=DEPTH-1 does not wrap. Instead the state goes to HALT with halted=1, instr_valid=0, and the extra output fault (1 bit) is set to 1. fault is cleared by reset or run.
- Not defined: the PC wraps to 0 and the fault port is absent.

Decomposition:
- Shared package proc_pkg holds:
  - typedef instr_t (12-bit packed struct: opcode, operand, imm)
  - localparam OP_HALT=4'hF, OP_NOP=4'h0
  - enum fetch_state_t {IDLE, FETCH, HALT}
- One sub-module: instr_mem (DEPTH x 12, 1 sync write port, 1 combinational read port).
- PC/FSM logic lives in instr_fetch.

Test Plan:
1. Load mem[0..3] = 12'h1D4, 12'h212, 12'h333, 12'hF00; pulse run -> instruction 1D4, 212, 333, F00 on 4 consecutive cycles with instr_pc 0..3 and instr_valid=1. Next cycle: halted=1, instr_valid=0.
2. Same program, stall=1 for 2 cycles while 12'h212 is shown -> 12'h212 and instr_pc=1 held for 3 cycles, then 12'h333.
3. redirect=1, redirect_pc=4'h0 while 12'h333 is shown -> instr_valid=0 for 1 cycle, then 12'h1D4 with instr_pc=0. Repeat with stall=1 asserted as well -> same result.
4. prog_we=1 to addr 2 with data 12'hABC during FETCH -> mem[2] unchanged, 12'h333 still fetched. The same write in HALT succeeds, and after run 12'hABC appears at instr_pc=2.
5. No HALT word, 16-word program, fetch runs past the end:
   - Macro undefined: instr_pc goes 15 -> 0, instr_valid stays 1.
   - Macro defined: after pc=15, halted=1 and fault=1.
6. Drive rst=0 asynchronously mid-fetch (not aligned to clk) -> instr_valid=0, instruction=000 and halted=0 immediately. After release, the block stays IDLE until run.
